// File: rtl/fetch_queue_pkg.sv
// Shared constants for the IF->ID fetch queue.
// Instruction width and the bubble encoding injected when empty.
package fetch_queue_pkg;

  localparam int INSTR_WIDTH = 32;
  localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = '0;

endpackage

// File: rtl/fetch_queue_if.sv
// Push/pop handshake bundle between IF, the fetch queue and ID.
// master = pipeline side, slave = queue side.
interface fetch_queue_if
  import fetch_queue_pkg::*;
#(
  parameter int DATA_W = INSTR_WIDTH,
  parameter int PC_W   = 32
);

  logic              push_valid;
  logic [DATA_W-1:0] push_instr;
  logic [PC_W-1:0]   push_pc;
  logic              push_ready;
  logic              pop_ready;
  logic              pop_valid;
  logic [DATA_W-1:0] pop_instr;
  logic [PC_W-1:0]   pop_pc;

  modport master (
    output push_valid,
    output push_instr,
    output push_pc,
    input  push_ready,
    output pop_ready,
    input  pop_valid,
    input  pop_instr,
    input  pop_pc
  );

  modport slave (
    input  push_valid,
    input  push_instr,
    input  push_pc,
    output push_ready,
    input  pop_ready,
    output pop_valid,
    output pop_instr,
    output pop_pc
  );

endinterface

// File: rtl/fetch_queue.sv
// Instruction FIFO between IF and ID; flushed on branch redirect.
// Wrap-bit pointers give count; empty masks stale storage to NOP.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DATA_W = INSTR_WIDTH,
  parameter int PC_W   = 32,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  fetch_queue_if.slave             q,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic [15:0]              drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [DATA_W-1:0] mem_instr [DEPTH];
  logic [PC_W-1:0]   mem_pc    [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;
  logic          do_push;
  logic          do_pop;
  logic [16:0]   drop_sum;
  logic [15:0]   drop_nxt;

  assign wr_idx = wr_ptr[AW-1:0];
  assign rd_idx = rd_ptr[AW-1:0];

  assign count = wr_ptr - rd_ptr;
  assign full  = (count == PW'(DEPTH));
  assign empty = (count == '0);

  // ready comes from registered pointers only, never from pop_ready
  assign q.push_ready = !full;
  assign q.pop_valid  = !empty;
  assign q.pop_instr  = empty ? DATA_W'(NOP_INSTR) : mem_instr[rd_idx];
  assign q.pop_pc     = empty ? '0 : mem_pc[rd_idx];

  assign do_push = q.push_valid && !full && !flush;
  assign do_pop  = !empty && q.pop_ready && !flush;

  assign drop_sum = {1'b0, drop_cnt} + 17'(count);
  assign drop_nxt = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      drop_cnt <= '0;
    end else begin
      unique case (1'b1)
        flush: begin
          wr_ptr   <= '0;
          rd_ptr   <= '0;
          drop_cnt <= drop_nxt;
        end
        default: begin
          if (do_push) wr_ptr <= wr_ptr + PW'(1);
          if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_instr[wr_idx] <= q.push_instr;
      mem_pc[wr_idx]    <= q.push_pc;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a queue-based reference model.
// Literal checks pin the scenarios; a negedge process checks every cycle.
module tb_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 0;
  logic        rst = 0;
  logic        flush = 0;
  logic [2:0]  count;
  logic        full;
  logic        empty;
  logic [15:0] drop_cnt;

  int checks = 0;
  int errors = 0;

  fetch_queue_if #(.DATA_W(32), .PC_W(32)) bus ();

  fetch_queue #(.DATA_W(32), .PC_W(32), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .q        (bus),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  ent_t mq[$];
  int   mdrop = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: FIFO semantics expressed with a SV queue
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      mdrop = 0;
    end else if (flush) begin
      mdrop = mdrop + mq.size();
      if (mdrop > 65535) mdrop = 65535;
      mq.delete();
    end else begin
      bit pop_ok, push_ok;
      ent_t e;
      pop_ok  = (mq.size() > 0) && bus.pop_ready;
      push_ok = bus.push_valid && (mq.size() < DEPTH);
      if (pop_ok) void'(mq.pop_front());
      if (push_ok) begin
        e.instr = bus.push_instr;
        e.pc    = bus.push_pc;
        mq.push_back(e);
      end
    end
  end

  always @(negedge clk) begin
    int n;
    n = mq.size();
    check("m_count", 64'(count), 64'(n));
    check("m_full", 64'(full), 64'(n == DEPTH));
    check("m_empty", 64'(empty), 64'(n == 0));
    check("m_push_ready", 64'(bus.push_ready), 64'(n != DEPTH));
    check("m_pop_valid", 64'(bus.pop_valid), 64'(n != 0));
    check("m_pop_instr", 64'(bus.pop_instr), n != 0 ? 64'(mq[0].instr) : 64'd0);
    check("m_pop_pc", 64'(bus.pop_pc), n != 0 ? 64'(mq[0].pc) : 64'd0);
    check("m_drop_cnt", 64'(drop_cnt), 64'(mdrop));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic v, logic [31:0] d, logic r);
    bus.push_valid = v;
    bus.push_instr = d;
    bus.push_pc    = {d[29:0], 2'b00};
    bus.pop_ready  = r;
  endtask

  task automatic reset_vals(string tag);
    check({tag, "_count"}, 64'(count), 64'd0);
    check({tag, "_empty"}, 64'(empty), 64'd1);
    check({tag, "_full"}, 64'(full), 64'd0);
    check({tag, "_push_ready"}, 64'(bus.push_ready), 64'd1);
    check({tag, "_pop_valid"}, 64'(bus.pop_valid), 64'd0);
    check({tag, "_pop_instr"}, 64'(bus.pop_instr), 64'd0);
    check({tag, "_pop_pc"}, 64'(bus.pop_pc), 64'd0);
    check({tag, "_drop"}, 64'(drop_cnt), 64'd0);
  endtask

  initial begin
    drive(0, 0, 0);
    #1;
    reset_vals("rst0");
    cyc();
    cyc();
    rst = 1;
    cyc();

    // S1: fill to full, fifth push refused
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'h11 * (i + 1), 0);
      cyc();
    end
    check("s1_full", 64'(full), 64'd1);
    check("s1_push_ready", 64'(bus.push_ready), 64'd0);
    check("s1_count", 64'(count), 64'd4);
    drive(1, 32'h55, 0);
    cyc();
    check("s1_count5", 64'(count), 64'd4);
    check("s1_head", 64'(bus.pop_instr), 64'h11);

    // S2: drain in order
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1);
      check("s2_pop", 64'(bus.pop_instr), 64'(32'h11 * (i + 1)));
      cyc();
    end
    check("s2_empty", 64'(empty), 64'd1);
    check("s2_nop", 64'(bus.pop_instr), 64'd0);

    // S3: steady push+pop at count 2 across wrap
    drive(1, 32'hA0, 0);
    cyc();
    drive(1, 32'hA1, 0);
    cyc();
    for (int i = 0; i < 10; i++) begin
      drive(1, 32'hA2 + i, 1);
      check("s3_pop", 64'(bus.pop_instr), 64'(32'hA0 + i));
      check("s3_pc", 64'(bus.pop_pc), 64'({30'(32'hA0 + i), 2'b00}));
      cyc();
      check("s3_count", 64'(count), 64'd2);
    end

    // S4: flush at count 3 with concurrent push
    drive(1, 32'hB0, 0);
    cyc();
    check("s4_pre", 64'(count), 64'd3);
    drive(1, 32'hDEAD, 0);
    flush = 1;
    cyc();
    flush = 0;
    check("s4_count", 64'(count), 64'd0);
    check("s4_drop", 64'(drop_cnt), 64'd3);
    check("s4_pop_valid", 64'(bus.pop_valid), 64'd0);
    drive(1, 32'hC0, 0);
    cyc();
    check("s4_after", 64'(bus.pop_instr), 64'hC0);
    check("s4_after_cnt", 64'(count), 64'd1);
    drive(0, 0, 1);
    cyc();

    // S5: push into empty with pop_ready high
    drive(1, 32'hE0, 1);
    check("s5_pv0", 64'(bus.pop_valid), 64'd0);
    cyc();
    drive(0, 0, 1);
    check("s5_pv1", 64'(bus.pop_valid), 64'd1);
    check("s5_data", 64'(bus.pop_instr), 64'hE0);
    cyc();
    check("s5_empty", 64'(empty), 64'd1);

    // S6: async reset between edges at count 2
    drive(1, 32'hF0, 0);
    cyc();
    drive(1, 32'hF1, 0);
    cyc();
    drive(0, 0, 0);
    check("s6_pre", 64'(count), 64'd2);
    #2;
    rst = 0;
    #1;
    reset_vals("s6");
    cyc();
    rst = 1;
    cyc();
    reset_vals("s6_post");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
